sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller port (23-bit word address, 32-bit data, req/ack/valid handshake) between one ROM-download write port and NUM_PORTS game read ports, such as CPU ROM, sound ROM, tile ROM and sprite ROM.
- Sits between the game core's ROM fetch logic and the sdram controller instance.
- Download writes have absolute priority; reads are granted round-robin.
- Returned read data is steered to the requester that issued the read, via an in-order tag queue.

---
 rtl/sdram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Arbitrates one SDRAM controller port between a download writer and
// NUM_PORTS round-robin readers, steering read returns via a tag queue.
module sdram_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            dl_req,
    input  logic [ADDR_WIDTH-1:0]           dl_addr,
    input  logic [DATA_WIDTH-1:0]           dl_data,
    output logic                            dl_ack,
    input  logic [NUM_PORTS-1:0]            rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]            rd_ack,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_q,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  we_r;
    logic                  own_wr;
    logic [PW-1:0]         owner;
    logic [PW-1:0]         last;
    logic [PW-1:0]         tags [DEPTH];
    logic [QW-1:0]         wptr;
    logic [QW-1:0]         rptr;
    logic [CW-1:0]         count;

    logic          found;
    logic [PW-1:0] pick;
    logic          full;
    logic          grant_wr;
    logic          grant_rd;
    logic          hit;
    logic          push;
    logic          pop;

    // Round-robin search starting just after the last granted port.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (!found && rd_req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign full     = (count == CW'(DEPTH));
    assign grant_wr = (state == IDLE) && dl_req;
    assign grant_rd = (state == IDLE) && !dl_req && found && !full;
    assign hit      = (state == BUSY) && sdram_ack;
    assign push     = hit && !own_wr;
    assign pop      = sdram_valid && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (grant_wr || grant_rd) state_nx = BUSY;
            BUSY: if (sdram_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sdram_req = (state == BUSY);
        dl_ack    = hit && own_wr;
        rd_ack    = '0;
        rd_valid  = '0;
        if (push) rd_ack[owner] = 1'b1;
        if (pop)  rd_valid[tags[rptr]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r <= '0;
            data_r <= '0;
            we_r   <= 1'b0;
            own_wr <= 1'b0;
            owner  <= '0;
            last   <= PW'(NUM_PORTS - 1);
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
        end else begin
            if (grant_wr) begin
                addr_r <= dl_addr;
                data_r <= dl_data;
                we_r   <= 1'b1;
                own_wr <= 1'b1;
            end else if (grant_rd) begin
                addr_r <= rd_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                we_r   <= 1'b0;
                own_wr <= 1'b0;
                owner  <= pick;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
                last <= owner;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        if (push) tags[wptr] <= owner;
    end

    assign sdram_addr = addr_r;
    assign sdram_data = data_r;
    assign sdram_we   = we_r;
    assign rd_q       = sdram_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a hand-driven controller model
// acks grants and returns data while outputs are compared to constants.
module tb_sdram_arbiter;

    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             dl_req;
    logic [AW-1:0]    dl_addr;
    logic [DW-1:0]    dl_data;
    logic             dl_ack;
    logic [NP-1:0]    rd_req;
    logic [NP*AW-1:0] rd_addr;
    logic [NP-1:0]    rd_ack;
    logic [NP-1:0]    rd_valid;
    logic [DW-1:0]    rd_q;
    logic [AW-1:0]    sdram_addr;
    logic [DW-1:0]    sdram_data;
    logic             sdram_we;
    logic             sdram_req;
    logic             sdram_ack;
    logic             sdram_valid;
    logic [DW-1:0]    sdram_q;

    int checks = 0;
    int errors = 0;

    sdram_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_ack(dl_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_q(rd_q),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data),
        .sdram_we(sdram_we), .sdram_req(sdram_req),
        .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
        .sdram_q(sdram_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the drive point, 2 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    // Wait for a controller request, check it, ack it, drop acked reqs.
    task automatic do_ack(input string tag, input logic [AW-1:0] ea,
                          input logic ewe, input logic [NP-1:0] erd,
                          input logic edl, input logic [DW-1:0] ed);
        logic [NP-1:0] acks;
        bit seen;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            #1;
            if (sdram_req) begin
                seen = 1;
                break;
            end
            cyc();
        end
        if (!seen) chk({tag, "_timeout"}, 64'(sdram_req), 64'd1);
        chk({tag, "_addr"}, 64'(sdram_addr), 64'(ea));
        chk({tag, "_we"}, 64'(sdram_we), 64'(ewe));
        if (ewe) chk({tag, "_data"}, 64'(sdram_data), 64'(ed));
        sdram_ack = 1'b1;
        #1;
        chk({tag, "_rd_ack"}, 64'(rd_ack), 64'(erd));
        chk({tag, "_dl_ack"}, 64'(dl_ack), 64'(edl));
        acks = rd_ack;
        cyc();
        sdram_ack = 1'b0;
        rd_req    = rd_req & ~acks;
        if (edl) dl_req = 1'b0;
    endtask

    task automatic do_valid(input string tag, input logic [DW-1:0] q,
                            input logic [NP-1:0] ev);
        sdram_valid = 1'b1;
        sdram_q     = q;
        #1;
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(ev));
        chk({tag, "_rd_q"}, 64'(rd_q), 64'(q));
        cyc();
        sdram_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        dl_req      = 1'b0;
        dl_addr     = '0;
        dl_data     = '0;
        rd_req      = '0;
        rd_addr     = '0;
        sdram_ack   = 1'b0;
        sdram_valid = 1'b0;
        sdram_q     = '0;
        cyc();
        cyc();
        #1;
        chk("rst_req", 64'(sdram_req), 64'd0);
        chk("rst_we", 64'(sdram_we), 64'd0);
        chk("rst_addr", 64'(sdram_addr), 64'd0);
        chk("rst_data", 64'(sdram_data), 64'd0);
        chk("rst_dl_ack", 64'(dl_ack), 64'd0);
        chk("rst_rd_ack", 64'(rd_ack), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        reset = 1'b0;
        cyc();

        // Single read on port 2
        set_addr(2, 23'h001234);
        rd_req = 4'b0100;
        #1;
        chk("t1_latency", 64'(sdram_req), 64'd0);
        cyc();
        #1;
        chk("t1_req", 64'(sdram_req), 64'd1);
        cyc();
        cyc();
        do_ack("t1", 23'h001234, 1'b0, 4'b0100, 1'b0, '0);
        #1;
        chk("t1_idle", 64'(sdram_req), 64'd0);
        do_valid("t1v", 32'hDEADBEEF, 4'b0100);

        // Round robin, each port re-raising after its valid
        pulse_reset();
        for (int p = 0; p < NP; p++) set_addr(p, 23'h000100 + AW'(p));
        rd_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int p;
            p = g % NP;
            do_ack($sformatf("t2_g%0d", g), 23'h000100 + AW'(p),
                   1'b0, 4'(1 << p), 1'b0, '0);
            if (g == 4) rd_req = '0;
            do_valid($sformatf("t2v_g%0d", g), 32'hA000 + DW'(g),
                     4'(1 << p));
            if (g < 4) rd_req[p] = 1'b1;
        end

        // Download priority over simultaneous reads
        pulse_reset();
        set_addr(0, 23'h000200);
        set_addr(1, 23'h000201);
        dl_addr = 23'h000010;
        dl_data = 32'h11223344;
        dl_req  = 1'b1;
        rd_req  = 4'b0011;
        do_ack("t3_wr", 23'h000010, 1'b1, 4'b0000, 1'b1, 32'h11223344);
        do_ack("t3_r0", 23'h000200, 1'b0, 4'b0001, 1'b0, '0);
        do_ack("t3_r1", 23'h000201, 1'b0, 4'b0010, 1'b0, '0);
        do_valid("t3v0", 32'h0BAD0000, 4'b0001);
        do_valid("t3v1", 32'h0BAD0001, 4'b0010);
        do_valid("t5_stray", 32'h0BAD0002, 4'b0000);

        // Queue full: four reads outstanding on port 0
        set_addr(0, 23'h000300);
        set_addr(1, 23'h000301);
        for (int n = 0; n < 4; n++) begin
            rd_req[0] = 1'b1;
            do_ack($sformatf("t4_r%0d", n), 23'h000300, 1'b0,
                   4'b0001, 1'b0, '0);
        end
        rd_req[1] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            #1;
            chk($sformatf("t4_full%0d", n), 64'(sdram_req), 64'd0);
        end
        dl_addr = 23'h000020;
        dl_data = 32'h55667788;
        dl_req  = 1'b1;
        do_ack("t4_wr", 23'h000020, 1'b1, 4'b0000, 1'b1, 32'h55667788);
        do_valid("t4v0", 32'hC0000000, 4'b0001);
        do_ack("t4_r5", 23'h000301, 1'b0, 4'b0010, 1'b0, '0);
        do_valid("t4v1", 32'hC0000001, 4'b0001);
        do_valid("t4v2", 32'hC0000002, 4'b0001);
        do_valid("t4v3", 32'hC0000003, 4'b0001);
        do_valid("t4v4", 32'hC0000004, 4'b0010);

        // Download arriving while a read is in flight
        set_addr(2, 23'h000400);
        rd_req[2] = 1'b1;
        cyc();
        dl_addr = 23'h000030;
        dl_data = 32'h00000099;
        dl_req  = 1'b1;
        do_ack("t7_rd", 23'h000400, 1'b0, 4'b0100, 1'b0, '0);
        do_ack("t7_wr", 23'h000030, 1'b1, 4'b0000, 1'b1, 32'h00000099);
        do_valid("t7v", 32'hE0000000, 4'b0100);

        // Reset while BUSY with two tags outstanding
        set_addr(0, 23'h000500);
        rd_req[0] = 1'b1;
        do_ack("t6_r0", 23'h000500, 1'b0, 4'b0001, 1'b0, '0);
        rd_req[0] = 1'b1;
        do_ack("t6_r1", 23'h000500, 1'b0, 4'b0001, 1'b0, '0);
        rd_req[0] = 1'b1;
        cyc();
        #1;
        chk("t6_busy", 64'(sdram_req), 64'd1);
        reset = 1'b1;
        cyc();
        #1;
        chk("t6_req", 64'(sdram_req), 64'd0);
        chk("t6_addr", 64'(sdram_addr), 64'd0);
        reset  = 1'b0;
        rd_req = '0;
        do_valid("t6v0", 32'hF0000000, 4'b0000);
        do_valid("t6v1", 32'hF0000001, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
